// File: rtl/param_bus_datapath.sv
// Single-bus datapath slice: GPR file, Y/Z/HI/LO/PC/IR/MAR/MDR, ALU,
// multicycle signed mul/div sequencer and req/ack memory handshake.
//
// state   | meaning
// MD_IDLE | no mul/div in flight, single-cycle ALU ops may load Z
// MD_RUN  | operands latched, counting WIDTH..1
// MD_DONE | product/quotient written to Z at this edge
// M_IDLE  | no memory transaction outstanding
// M_WAIT  | mem_req held high until mem_ack
module param_bus_datapath #(
  parameter int WIDTH = 32,
  parameter int NREGS = 16,
  parameter int RSW   = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic [3:0]       bus_src,
  input  logic [RSW-1:0]   gpr_sel,
  input  logic             ba_mode,
  input  logic             gpr_in,
  input  logic             Yin,
  input  logic             Zin,
  input  logic             HIin,
  input  logic             LOin,
  input  logic             PCin,
  input  logic             MARin,
  input  logic             MDRin,
  input  logic             IRin,
  input  logic             IncPC,
  input  logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] imm_in,
  input  logic [WIDTH-1:0] inport_data,
  input  logic             mem_rd,
  input  logic             mem_wr,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_ack,
  output logic             busy,
  output logic [WIDTH-1:0] ir_out,
  output logic [WIDTH-1:0] Busout
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] WMOD     = WIDTH'(WIDTH);
  localparam logic [CW-1:0]    CNT_LOAD = CW'(WIDTH);

  typedef enum logic [1:0] {MD_IDLE, MD_RUN, MD_DONE} md_state_t;
  typedef enum logic {M_IDLE, M_WAIT} mem_state_t;

  logic [WIDTH-1:0]   gpr [NREGS];
  logic [WIDTH-1:0]   y_q, hi_q, lo_q, pc_q, ir_q, mar_q, mdr_q;
  logic [2*WIDTH-1:0] z_q;
  logic [WIDTH-1:0]   bus;

  md_state_t          md_state, md_next;
  logic [CW-1:0]      md_cnt;
  logic [WIDTH-1:0]   op_a, op_b;
  logic               op_div;
  logic               md_busy, md_wr_z, md_start, is_muldiv;

  mem_state_t         m_state, m_next;
  logic               we_q, mem_start;

  always_comb begin
    bus = '0;
    case (bus_src)
      4'd0:    bus = (ba_mode && gpr_sel == '0) ? '0 : gpr[gpr_sel];
      4'd1:    bus = hi_q;
      4'd2:    bus = lo_q;
      4'd3:    bus = z_q[2*WIDTH-1:WIDTH];
      4'd4:    bus = z_q[WIDTH-1:0];
      4'd5:    bus = pc_q;
      4'd6:    bus = mdr_q;
      4'd7:    bus = inport_data;
      4'd8:    bus = imm_in;
      default: bus = '0;
    endcase
  end

  assign Busout = bus;

  logic [WIDTH-1:0] sh_amt, alu_res;

  always_comb begin
    sh_amt  = bus % WMOD;
    alu_res = bus;
    case (alu_op)
      4'd0:    alu_res = y_q + bus;
      4'd1:    alu_res = y_q - bus;
      4'd2:    alu_res = y_q & bus;
      4'd3:    alu_res = y_q | bus;
      4'd4:    alu_res = y_q >> sh_amt;
      4'd5:    alu_res = $signed(y_q) >>> sh_amt;
      4'd6:    alu_res = y_q << sh_amt;
      4'd7:    alu_res = (y_q >> sh_amt) | (y_q << (WMOD - sh_amt));
      4'd8:    alu_res = (y_q << sh_amt) | (y_q >> (WMOD - sh_amt));
      4'd9:    alu_res = -bus;
      4'd10:   alu_res = ~bus;
      default: alu_res = bus;
    endcase
    // IncPC overrides whatever op the control unit left on alu_op
    if (IncPC) alu_res = bus + {{(WIDTH-1){1'b0}}, 1'b1};
  end

  // Signed mul/div from latched operands; division works on magnitudes so
  // the most-negative / -1 case wraps deterministically.
  logic [2*WIDTH-1:0] prod, div_res;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag, b_safe, q_mag, r_mag, quot, rem;

  always_comb begin
    prod    = {{WIDTH{op_a[WIDTH-1]}}, op_a} * {{WIDTH{op_b[WIDTH-1]}}, op_b};
    a_neg   = op_a[WIDTH-1];
    b_neg   = op_b[WIDTH-1];
    a_mag   = a_neg ? -op_a : op_a;
    b_mag   = b_neg ? -op_b : op_b;
    b_safe  = (op_b == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : b_mag;
    q_mag   = a_mag / b_safe;
    r_mag   = a_mag % b_safe;
    quot    = (a_neg ^ b_neg) ? -q_mag : q_mag;
    rem     = a_neg ? -r_mag : r_mag;
    div_res = (op_b == '0) ? {op_a, {WIDTH{1'b1}}} : {rem, quot};
  end

  assign is_muldiv = !IncPC && (alu_op == 4'd11 || alu_op == 4'd12);
  assign md_start  = Zin && is_muldiv && (md_state == MD_IDLE);

  always_ff @(posedge clk) begin
    if (Reset) begin
      md_state <= MD_IDLE;
      md_cnt   <= '0;
      op_a     <= '0;
      op_b     <= '0;
      op_div   <= 1'b0;
    end else begin
      md_state <= md_next;
      if (md_start) begin
        op_a   <= y_q;
        op_b   <= bus;
        op_div <= (alu_op == 4'd12);
        md_cnt <= CNT_LOAD;
      end else if (md_state == MD_RUN) begin
        md_cnt <= md_cnt - 1'b1;
      end
    end
  end

  always_comb begin
    md_next = md_state;
    case (md_state)
      MD_IDLE: if (md_start) md_next = MD_RUN;
      MD_RUN:  if (md_cnt == CW'(1)) md_next = MD_DONE;
      MD_DONE: md_next = MD_IDLE;
      default: md_next = MD_IDLE;
    endcase
  end

  always_comb begin
    md_busy = (md_state != MD_IDLE);
    md_wr_z = (md_state == MD_DONE);
  end

  assign mem_start = (mem_rd || mem_wr) && (m_state == M_IDLE);

  always_ff @(posedge clk) begin
    if (Reset) begin
      m_state <= M_IDLE;
      we_q    <= 1'b0;
    end else begin
      m_state <= m_next;
      if (mem_start) we_q <= mem_wr;
    end
  end

  always_comb begin
    m_next = m_state;
    case (m_state)
      M_IDLE:  if (mem_start) m_next = M_WAIT;
      M_WAIT:  if (mem_ack) m_next = M_IDLE;
      default: m_next = M_IDLE;
    endcase
  end

  always_comb begin
    mem_req = (m_state == M_WAIT);
    mem_we  = mem_req && we_q;
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      for (int i = 0; i < NREGS; i++) gpr[i] <= '0;
      y_q   <= '0;
      z_q   <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      pc_q  <= '0;
      ir_q  <= '0;
      mar_q <= '0;
      mdr_q <= '0;
    end else begin
      if (gpr_in) gpr[gpr_sel] <= bus;
      if (Yin && !md_busy) y_q <= bus;
      if (md_wr_z) z_q <= op_div ? div_res : prod;
      else if (Zin && !md_busy && !is_muldiv) z_q <= {{WIDTH{1'b0}}, alu_res};
      if (HIin) hi_q <= bus;
      if (LOin) lo_q <= bus;
      if (PCin) pc_q <= bus;
      if (IRin) ir_q <= bus;
      if (MARin && !mem_req) mar_q <= bus;
      if (mem_req && mem_ack && !we_q) mdr_q <= mem_rdata;
      else if (MDRin && !mem_req) mdr_q <= bus;
    end
  end

  assign busy      = md_busy | mem_req;
  assign mem_addr  = mar_q;
  assign mem_wdata = mdr_q;
  assign ir_out    = ir_q;

endmodule

// File: tb/tb_param_bus_datapath.sv
// Self-checking bench for param_bus_datapath: a 32-bit/16-reg instance for
// most scenarios and a 16-bit/8-reg instance for the parametric checks.
module tb_param_bus_datapath;

  int n_tests = 0;
  int n_fail  = 0;

  logic        clk = 1'b0;
  logic        Reset;
  logic [3:0]  bus_src, gpr_sel, alu_op;
  logic        ba_mode, gpr_in, Yin, Zin, HIin, LOin, PCin, MARin, MDRin, IRin, IncPC;
  logic [31:0] imm_in, inport_data, mem_rdata;
  logic        mem_rd, mem_wr, mem_ack;
  logic        mem_req, mem_we, busy;
  logic [31:0] mem_addr, mem_wdata, ir_out, Busout;

  logic [3:0]  bus_src_p, alu_op_p;
  logic [2:0]  gpr_sel_p;
  logic        gpr_in_p, Yin_p, Zin_p;
  logic [15:0] imm_p;
  logic        mem_req_p, mem_we_p, busy_p;
  logic [15:0] mem_addr_p, mem_wdata_p, ir_out_p, Busout_p;

  always #5 clk = ~clk;

  param_bus_datapath #(.WIDTH(32), .NREGS(16)) u_dut (
    .clk(clk), .Reset(Reset), .bus_src(bus_src), .gpr_sel(gpr_sel), .ba_mode(ba_mode),
    .gpr_in(gpr_in), .Yin(Yin), .Zin(Zin), .HIin(HIin), .LOin(LOin), .PCin(PCin),
    .MARin(MARin), .MDRin(MDRin), .IRin(IRin), .IncPC(IncPC), .alu_op(alu_op),
    .imm_in(imm_in), .inport_data(inport_data), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .busy(busy), .ir_out(ir_out), .Busout(Busout)
  );

  param_bus_datapath #(.WIDTH(16), .NREGS(8)) u_p16 (
    .clk(clk), .Reset(Reset), .bus_src(bus_src_p), .gpr_sel(gpr_sel_p), .ba_mode(1'b0),
    .gpr_in(gpr_in_p), .Yin(Yin_p), .Zin(Zin_p), .HIin(1'b0), .LOin(1'b0), .PCin(1'b0),
    .MARin(1'b0), .MDRin(1'b0), .IRin(1'b0), .IncPC(1'b0), .alu_op(alu_op_p),
    .imm_in(imm_p), .inport_data(16'h0), .mem_rd(1'b0), .mem_wr(1'b0),
    .mem_req(mem_req_p), .mem_we(mem_we_p), .mem_addr(mem_addr_p), .mem_wdata(mem_wdata_p),
    .mem_rdata(16'h0), .mem_ack(1'b0), .busy(busy_p), .ir_out(ir_out_p), .Busout(Busout_p)
  );

  // Reference model, written from the operation definitions.
  function automatic logic [31:0] alu_model(input int op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    int s;
    s = int'(b % 32);
    r = b;
    case (op)
      0: r = a + b;
      1: r = a - b;
      2: r = a & b;
      3: r = a | b;
      4: for (int i = 0; i < 32; i++) r[i] = (i + s < 32) ? a[i+s] : 1'b0;
      5: for (int i = 0; i < 32; i++) r[i] = (i + s < 32) ? a[i+s] : a[31];
      6: for (int i = 0; i < 32; i++) r[i] = (i - s >= 0) ? a[i-s] : 1'b0;
      7: for (int i = 0; i < 32; i++) r[i] = a[(i + s) % 32];
      8: for (int i = 0; i < 32; i++) r[i] = a[(i - s + 32) % 32];
      9: r = 32'd0 - b;
      10: r = ~b;
      default: r = b;
    endcase
    return r;
  endfunction

  function automatic logic [63:0] muldiv_model(input bit is_div, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (!is_div) return 64'(sa * sb);
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    bus_src = 4'd0; gpr_sel = 4'd0; alu_op = 4'd0; ba_mode = 1'b0;
    gpr_in = 1'b0; Yin = 1'b0; Zin = 1'b0; HIin = 1'b0; LOin = 1'b0; PCin = 1'b0;
    MARin = 1'b0; MDRin = 1'b0; IRin = 1'b0; IncPC = 1'b0;
    mem_rd = 1'b0; mem_wr = 1'b0; mem_ack = 1'b0; mem_rdata = 32'd0;
    imm_in = 32'd0; inport_data = 32'd0;
    bus_src_p = 4'd0; gpr_sel_p = 3'd0; alu_op_p = 4'd0;
    gpr_in_p = 1'b0; Yin_p = 1'b0; Zin_p = 1'b0; imm_p = 16'd0;
  endtask

  task automatic put(input logic [31:0] v);
    bus_src = 4'd8;
    imm_in  = v;
  endtask

  task automatic read_src(input logic [3:0] s, input logic [3:0] sel, output logic [31:0] v);
    bus_src = s;
    gpr_sel = sel;
    #1;
    v = Busout;
  endtask

  task automatic read_z(output logic [63:0] z);
    logic [31:0] h, l;
    read_src(4'd3, 4'd0, h);
    read_src(4'd4, 4'd0, l);
    z = {h, l};
  endtask

  task automatic test_reset();
    logic [31:0] v;
    logic [63:0] z;
    clr(); put(32'hA5A5_1234); gpr_sel = 4'd5;
    gpr_in = 1'b1; Yin = 1'b1; HIin = 1'b1; LOin = 1'b1; PCin = 1'b1;
    IRin = 1'b1; MARin = 1'b1; MDRin = 1'b1;
    tick(); clr();
    put(32'd1); Zin = 1'b1; tick(); clr();
    Reset = 1'b1; tick(); Reset = 1'b0; clr();
    for (int s = 0; s <= 6; s++) begin
      read_src(4'(s), 4'd5, v);
      n_tests++;
      if (v !== 32'd0) begin n_fail++; $display("FAIL reset_src%0d got %h want 0", s, v); end
    end
    n_tests++;
    if ({ir_out, mem_addr, mem_wdata} !== 96'd0) begin
      n_fail++; $display("FAIL reset_regs ir=%h mar=%h mdr=%h want 0", ir_out, mem_addr, mem_wdata);
    end
    n_tests++;
    if ({busy, mem_req, mem_we} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags busy/req/we=%b want 000", {busy, mem_req, mem_we});
    end
    clr(); put(32'd0); Zin = 1'b1; tick(); clr(); read_z(z);
    n_tests++;
    if (z !== 64'd0) begin n_fail++; $display("FAIL reset_y Y+0 got %h want 0", z); end
  endtask

  task automatic test_ba_mode();
    clr(); put(32'h55); gpr_sel = 4'd0; gpr_in = 1'b1; tick(); clr();
    put(32'hAA); gpr_sel = 4'd1; gpr_in = 1'b1; tick(); clr();
    ba_mode = 1'b1; bus_src = 4'd0; gpr_sel = 4'd0; #1;
    n_tests++;
    if (Busout !== 32'd0) begin n_fail++; $display("FAIL ba_zero got %h want 0", Busout); end
    ba_mode = 1'b0; #1;
    n_tests++;
    if (Busout !== 32'h55) begin n_fail++; $display("FAIL ba_off got %h want 55", Busout); end
    ba_mode = 1'b1; gpr_sel = 4'd1; #1;
    n_tests++;
    if (Busout !== 32'hAA) begin n_fail++; $display("FAIL ba_gpr1 got %h want aa", Busout); end
    clr();
  endtask

  task automatic test_alu_random();
    logic [31:0] a, b;
    logic [3:0]  op;
    logic [63:0] z, exp;
    for (int i = 0; i < 40; i++) begin
      a  = $urandom;
      b  = (i % 3 == 0) ? 32'($urandom_range(0, 70)) : $urandom;
      op = 4'($urandom_range(0, 13));
      if (op >= 4'd11) op = op + 4'd2;
      clr(); put(a); Yin = 1'b1; tick(); clr();
      put(b); alu_op = op; Zin = 1'b1; tick(); clr();
      read_z(z);
      exp = {32'd0, alu_model(int'(op), a, b)};
      n_tests++;
      if (z !== exp) begin
        n_fail++; $display("FAIL alu op=%0d a=%h b=%h got %h want %h", op, a, b, z, exp);
      end
    end
  endtask

  task automatic test_incpc();
    logic [31:0] pc, v;
    logic [63:0] z;
    for (int i = 0; i < 4; i++) begin
      pc = (i == 0) ? 32'hFFFF_FFFF : $urandom;
      clr(); put(pc); PCin = 1'b1; tick(); clr();
      bus_src = 4'd5; IncPC = 1'b1; alu_op = (i == 0) ? 4'd11 : 4'($urandom_range(0, 15));
      Zin = 1'b1; tick(); clr();
      n_tests++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL incpc_busy got %b want 0", busy); end
      read_z(z);
      n_tests++;
      if (z !== {32'd0, pc + 32'd1}) begin
        n_fail++; $display("FAIL incpc_z pc=%h got %h want %h", pc, z, {32'd0, pc + 32'd1});
      end
      read_src(4'd5, 4'd0, v);
      n_tests++;
      if (v !== pc) begin n_fail++; $display("FAIL incpc_pc_hold got %h want %h", v, pc); end
    end
  endtask

  task automatic run_muldiv(input bit is_div, input logic [31:0] a, input logic [31:0] b, input bit disturb);
    logic [63:0] z_before, z, exp;
    logic [31:0] v;
    int cnt;
    clr(); put(a); gpr_sel = 4'd1; gpr_in = 1'b1; tick(); clr();
    put(b); gpr_sel = 4'd2; gpr_in = 1'b1; tick(); clr();
    bus_src = 4'd0; gpr_sel = 4'd1; Yin = 1'b1; tick(); clr();
    put(32'h0BAD_0000 ^ b); Zin = 1'b1; alu_op = 4'd13; tick(); clr();
    read_z(z_before);
    bus_src = 4'd0; gpr_sel = 4'd2; alu_op = is_div ? 4'd12 : 4'd11; Zin = 1'b1;
    tick(); clr();
    cnt = 0;
    while (busy && cnt < 200) begin
      cnt++;
      if (cnt == 33) begin
        read_z(z);
        n_tests++;
        if (z !== z_before) begin n_fail++; $display("FAIL md_z_early got %h want %h", z, z_before); end
      end
      if (disturb && cnt == 3) begin
        put(32'h1234_5678 ^ a); Yin = 1'b1; Zin = 1'b1; alu_op = 4'd0; HIin = 1'b1;
      end
      tick(); clr();
    end
    n_tests++;
    if (cnt != 33) begin n_fail++; $display("FAIL md_latency busy cycles got %0d want 33", cnt); end
    read_z(z);
    exp = muldiv_model(is_div, a, b);
    n_tests++;
    if (z !== exp) begin
      n_fail++; $display("FAIL md_result div=%0d a=%h b=%h got %h want %h", is_div, a, b, z, exp);
    end
    if (disturb) begin
      read_src(4'd1, 4'd0, v);
      n_tests++;
      if (v !== (32'h1234_5678 ^ a)) begin
        n_fail++; $display("FAIL md_hi_load got %h want %h", v, 32'h1234_5678 ^ a);
      end
      clr(); put(32'd0); Zin = 1'b1; tick(); clr(); read_z(z);
      n_tests++;
      if (z !== {32'd0, a}) begin n_fail++; $display("FAIL md_y_hold got %h want %h", z, {32'd0, a}); end
    end
  endtask

  task automatic test_mul();
    run_muldiv(1'b0, 32'd7, 32'hFFFF_FFFD, 1'b1);
    for (int i = 0; i < 3; i++) run_muldiv(1'b0, $urandom, $urandom, 1'b0);
  endtask

  task automatic test_div();
    run_muldiv(1'b1, 32'hFFFF_FFEF, 32'd5, 1'b0);
    run_muldiv(1'b1, 32'd9, 32'd0, 1'b0);
    run_muldiv(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    for (int i = 0; i < 3; i++) run_muldiv(1'b1, $urandom, 32'($urandom_range(1, 1000)) * ((i == 1) ? 32'hFFFF_FFFF : 32'd1), 1'b1);
  endtask

  task automatic test_mem_read();
    logic [31:0] v;
    int req_cycles;
    clr(); put(32'h40); MARin = 1'b1; tick(); clr();
    mem_rd = 1'b1; tick(); clr();
    req_cycles = 0;
    for (int i = 0; i < 8; i++) begin
      if (mem_req) begin
        req_cycles++;
        n_tests++;
        if (mem_addr !== 32'h40) begin n_fail++; $display("FAIL rd_addr_hold got %h want 40", mem_addr); end
      end
      if (i == 0) begin
        n_tests++;
        if ({busy, mem_we} !== 2'b10) begin n_fail++; $display("FAIL rd_flags busy/we=%b want 10", {busy, mem_we}); end
        put(32'h99); MARin = 1'b1; MDRin = 1'b1;
      end
      if (i == 2) begin mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D; end
      tick(); clr();
    end
    n_tests++;
    if (req_cycles != 3) begin n_fail++; $display("FAIL rd_req_cycles got %0d want 3", req_cycles); end
    read_src(4'd6, 4'd0, v);
    n_tests++;
    if (v !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL rd_mdr got %h want cafef00d", v); end
    n_tests++;
    if ({busy, mem_addr} !== {1'b0, 32'h40}) begin
      n_fail++; $display("FAIL rd_after busy=%b addr=%h want 0/40", busy, mem_addr);
    end
  endtask

  task automatic test_mem_write();
    logic [31:0] a, v, m;
    int req_cycles;
    a = $urandom; v = $urandom;
    clr(); put(v); MDRin = 1'b1; tick(); clr();
    put(a); MARin = 1'b1; tick(); clr();
    mem_rd = 1'b1; mem_wr = 1'b1; tick(); clr();
    n_tests++;
    if ({mem_req, mem_we} !== 2'b11) begin n_fail++; $display("FAIL wr_start req/we=%b want 11", {mem_req, mem_we}); end
    req_cycles = 0;
    for (int i = 0; i < 6; i++) begin
      if (mem_req) begin
        req_cycles++;
        n_tests++;
        if ({mem_addr, mem_wdata} !== {a, v}) begin
          n_fail++; $display("FAIL wr_hold addr=%h data=%h want %h %h", mem_addr, mem_wdata, a, v);
        end
      end
      if (i == 0) begin mem_rd = 1'b1; put(~v); MDRin = 1'b1; MARin = 1'b1; end
      if (i == 1) begin mem_ack = 1'b1; mem_rdata = ~v; end
      tick(); clr();
    end
    n_tests++;
    if (req_cycles != 2) begin n_fail++; $display("FAIL wr_req_cycles got %0d want 2", req_cycles); end
    mem_ack = 1'b1; mem_rdata = 32'h1111_1111; tick(); clr();
    read_src(4'd6, 4'd0, m);
    n_tests++;
    if ({mem_req, mem_we, m} !== {2'b00, v}) begin
      n_fail++; $display("FAIL wr_after req/we=%b mdr=%h want 00 %h", {mem_req, mem_we}, m, v);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] v, r;
    logic [63:0] z;
    v = $urandom;
    clr(); put(v); gpr_sel = 4'd3; gpr_in = 1'b1;
    HIin = 1'b1; LOin = 1'b1; PCin = 1'b1; IRin = 1'b1; Yin = 1'b1; MARin = 1'b1; MDRin = 1'b1;
    tick(); clr();
    bus_src = 4'd0; gpr_sel = 4'd3; alu_op = 4'd0; Zin = 1'b1;
    tick(); clr();
    n_tests++;
    if ({ir_out, mem_addr, mem_wdata} !== {v, v, v}) begin
      n_fail++; $display("FAIL multi_ir_mar_mdr %h %h %h want %h", ir_out, mem_addr, mem_wdata, v);
    end
    for (int s = 0; s <= 5; s++) begin
      if (s == 3 || s == 4) continue;
      read_src(4'(s), 4'd3, r);
      n_tests++;
      if (r !== v) begin n_fail++; $display("FAIL multi_src%0d got %h want %h", s, r, v); end
    end
    read_z(z);
    n_tests++;
    if (z !== {32'd0, v + v}) begin n_fail++; $display("FAIL multi_z got %h want %h", z, {32'd0, v + v}); end
  endtask

  task automatic test_reset_mid_mul();
    logic [63:0] z;
    logic [31:0] m;
    clr(); put(32'd5); Yin = 1'b1; tick(); clr();
    put(32'd6); Zin = 1'b1; tick(); clr();
    put(32'd3); alu_op = 4'd11; Zin = 1'b1; tick(); clr();
    for (int i = 0; i < 4; i++) tick();
    Reset = 1'b1; tick(); Reset = 1'b0;
    read_z(z);
    n_tests++;
    if ({busy, z} !== 65'd0) begin n_fail++; $display("FAIL rst_mul busy=%b z=%h want 0", busy, z); end
    clr();
    for (int i = 0; i < 40; i++) tick();
    read_z(z);
    n_tests++;
    if ({busy, z} !== 65'd0) begin n_fail++; $display("FAIL rst_mul_late busy=%b z=%h want 0", busy, z); end
    clr(); put(32'h40); MARin = 1'b1; tick(); clr();
    mem_rd = 1'b1; tick(); clr();
    Reset = 1'b1; tick(); Reset = 1'b0;
    n_tests++;
    if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_mem req=%b want 0", mem_req); end
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF; tick(); clr();
    read_src(4'd6, 4'd0, m);
    n_tests++;
    if ({mem_req, m} !== 33'd0) begin n_fail++; $display("FAIL rst_late_ack req=%b mdr=%h want 0", mem_req, m); end
  endtask

  task automatic test_param();
    logic [15:0] h, l;
    int cnt;
    clr(); bus_src_p = 4'd8; imm_p = 16'd3; Yin_p = 1'b1; tick(); clr();
    bus_src_p = 4'd8; imm_p = 16'd17; alu_op_p = 4'd6; Zin_p = 1'b1; tick(); clr();
    bus_src_p = 4'd4; #1; l = Busout_p; bus_src_p = 4'd3; #1; h = Busout_p;
    n_tests++;
    if ({h, l} !== 32'h0000_0006) begin n_fail++; $display("FAIL p16_shl17 got %h want 00000006", {h, l}); end
    bus_src_p = 4'd8; imm_p = 16'd17; alu_op_p = 4'd7; Zin_p = 1'b1; tick(); clr();
    bus_src_p = 4'd4; #1;
    n_tests++;
    if (Busout_p !== 16'h8001) begin n_fail++; $display("FAIL p16_ror17 got %h want 8001", Busout_p); end
    bus_src_p = 4'd8; imm_p = 16'hBEEF; gpr_sel_p = 3'd7; gpr_in_p = 1'b1; tick(); clr();
    bus_src_p = 4'd0; gpr_sel_p = 3'd7; #1;
    n_tests++;
    if (Busout_p !== 16'hBEEF) begin n_fail++; $display("FAIL p16_gpr7 got %h want beef", Busout_p); end
    bus_src_p = 4'd8; imm_p = 16'd7; Yin_p = 1'b1; tick(); clr();
    bus_src_p = 4'd8; imm_p = 16'hFFFD; alu_op_p = 4'd11; Zin_p = 1'b1; tick(); clr();
    cnt = 0;
    while (busy_p && cnt < 100) begin cnt++; tick(); end
    n_tests++;
    if (cnt != 17) begin n_fail++; $display("FAIL p16_latency got %0d want 17", cnt); end
    bus_src_p = 4'd4; #1; l = Busout_p; bus_src_p = 4'd3; #1; h = Busout_p;
    n_tests++;
    if ({h, l} !== 32'hFFFF_FFEB) begin n_fail++; $display("FAIL p16_mul got %h want ffffffeb", {h, l}); end
    clr();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clr();
    Reset = 1'b1;
    tick(); tick();
    Reset = 1'b0;
    test_reset();
    test_ba_mode();
    test_alu_random();
    test_incpc();
    test_mul();
    test_div();
    test_mem_read();
    test_mem_write();
    test_back_to_back();
    test_reset_mid_mul();
    test_param();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
